ddr_cmd_scheduler: RTL and testbench
====================================

// Module: ddr_cmd_scheduler
// PURPOSE
//  Shares one DDR bank array (8 banks = bank_grp x bank_no) between NUM_REQ requesters.
//  Round-robin arbitration; open-page row tracking; sequences PRE/ACT/RD/WR with tRP/tRCD spacing.
//  Inserts a periodic REFRESH. Sits between client ports and the memory command interface.
// PARAMETERS
//  NUM_REQ       2    number of requesters (2..4)
//  ROW_W         3    row address width
//  COL_W         3    column address width
//  T_RCD         2    cycles from cmd_act to cmd_rd/cmd_wr (>=1)
//  T_RP          2    cycles from cmd_pre to cmd_act (>=1)
//  T_RFC         5    cycles cmd_ref blocks the array (>=1)
//  REF_INTERVAL  64   cycles between refresh requests
// PORTS
//  clk_t        in   1               clock; all logic on posedge clk_t
//  reset        in   1               synchronous, active-high reset
//  req_valid    in   NUM_REQ         request pending per requester
//  req_rwb      in   NUM_REQ         1 = write, 0 = read
//  req_bank     in   3*NUM_REQ       {bank_grp,bank_no[1:0]} per requester, packed
//  req_row      in   ROW_W*NUM_REQ   row per requester, packed
//  req_col      in   COL_W*NUM_REQ   column per requester, packed
//  req_ready    out  NUM_REQ         one-hot 1-cycle accept pulse = command issued
//  cmd_act      out  1               ACTIVATE strobe
//  cmd_pre      out  1               PRECHARGE strobe
//  cmd_rd       out  1               READ strobe
//  cmd_wr       out  1               WRITE strobe
//  cmd_ref      out  1               REFRESH strobe
//  cmd_bank     out  3               {bank_grp,bank_no} for the current command
//  cmd_row      out  ROW_W           row for ACT/PRE
//  cmd_col      out  COL_W           column for RD/WR
//  busy         out  1               1 whenever state != IDLE
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; open_valid=0; rr pointer=0; ref counter=0; ref_pending=0.
//  - Reset mid-sequence: IDLE next cycle, open row dropped, in-flight request not acked.
//  - All outputs registered (Moore); command strobes mutually exclusive, 1 cycle each.
//  - Requester holds valid and fields stable until its req_ready; ready never without valid.
//  - Arbitration in IDLE only: round-robin from rr pointer; winner latched; rr = winner+1 mod NUM_REQ.
//  - Hit = open_valid && bank,row match winner. States:
//    IDLE: ref_pending -> (open_valid ? PRE : REF); else winner hit -> ACCESS;
//          winner miss -> (open_valid ? PRE : ACT); else stay.
//    PRE: cmd_pre=1 with open bank/row; open_valid=0 -> PRE_WAIT (T_RP-1 cycles) -> ACT or REF.
//    ACT: cmd_act=1 with winner bank/row; open row := winner -> ACT_WAIT (T_RCD-1) -> ACCESS.
//    ACCESS: cmd_rd or cmd_wr=1, cmd_col=winner col, req_ready[winner]=1 -> IDLE.
//    REF: cmd_ref=1 -> REF_WAIT (T_RFC-1) -> IDLE; clears ref counter and ref_pending.
//  - Zero-length waits when T_x=1: skip *_WAIT state.
//  - Latency: hit = ready 1 cycle after valid seen in IDLE; closed miss = 1+T_RCD;
//    open miss = 1+T_RP+T_RCD.
//  - Ref counter increments every cycle outside REF/REF_WAIT.
//    At REF_INTERVAL-1: ref_pending=1; counter saturates, no wrap.
//  - Refresh beats any valid request in IDLE; never preempts a started PRE/ACT/ACCESS sequence.
//  - No valid requests: stays IDLE, row stays open (open-page policy).
// CONFIGURATION
//  CLOSE_PAGE_EN defined: every ACCESS also closes the row.
//    ACCESS -> PRE (cmd_pre, T_RP wait) -> IDLE; open_valid always 0 in IDLE.
//    Every request = ACT+RD/WR+PRE.
//  Undefined: open-page policy as above.
// TESTING
//  1 reset: hold reset 3 cycles mid-ACT_WAIT -> all outputs 0, busy=0, next req does ACT (no PRE).
//  2 closed miss: req0 wr bank3 row5 col2 -> cmd_act(bank3,row5) at t+1; cmd_wr col2 + req_ready=01 at t+3.
//  3 hit vs miss: req0 rd bank3 row5 after test 2 -> cmd_rd at t+1, no ACT.
//    Then bank3 row6 -> cmd_pre(row5), cmd_act(row6) T_RP later, cmd_rd T_RCD after that.
//  4 round-robin: req0, req1 valid continuously, same row -> ready alternates 01,10,01,10.
//  5 refresh: valid requests held past cycle 64 with row open -> current access done, cmd_pre,
//    cmd_ref, 5 cycles no commands, then service resumes; counter restarts from 0.
//  6 CLOSE_PAGE_EN: two reads same bank/row -> each preceded by cmd_act, followed by cmd_pre.

Source files
------------

// File: rtl/ddr_cmd_scheduler.sv
// ddr_cmd_scheduler
//   Shares one 8-bank DDR array between NUM_REQ requesters. Round-robin
//   arbitration, open-page row tracking, PRE/ACT/RD/WR sequencing with
//   tRP/tRCD spacing, and a periodic REFRESH that takes priority in IDLE.
//   All outputs are registered: they are computed from the next state, so
//   each strobe is high during the cycle the FSM sits in that state.
// Config macro: CLOSE_PAGE_EN -- when defined, every ACCESS is followed by
//   a PRECHARGE, so no row is left open between requests.
// Ports:
//   clk_t, reset              clock, synchronous active-high reset
//   req_valid/rwb[NUM_REQ]    request pending / 1=write
//   req_bank/row/col          packed per-requester bank {grp,no}, row, column
//   req_ready[NUM_REQ]        one-hot accept pulse, coincides with RD/WR
//   cmd_act/pre/rd/wr/ref     one-cycle, mutually exclusive command strobes
//   cmd_bank/row/col          command address (row on ACT/PRE, col on RD/WR)
//   busy                      FSM not in IDLE
module ddr_cmd_scheduler #(
  parameter int NUM_REQ      = 2,
  parameter int ROW_W        = 3,
  parameter int COL_W        = 3,
  parameter int T_RCD        = 2,
  parameter int T_RP         = 2,
  parameter int T_RFC        = 5,
  parameter int REF_INTERVAL = 64
) (
  input  logic                     clk_t,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0]       req_rwb,
  input  logic [3*NUM_REQ-1:0]     req_bank,
  input  logic [ROW_W*NUM_REQ-1:0] req_row,
  input  logic [COL_W*NUM_REQ-1:0] req_col,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     cmd_act,
  output logic                     cmd_pre,
  output logic                     cmd_rd,
  output logic                     cmd_wr,
  output logic                     cmd_ref,
  output logic [2:0]               cmd_bank,
  output logic [ROW_W-1:0]         cmd_row,
  output logic [COL_W-1:0]         cmd_col,
  output logic                     busy
);
  localparam int IW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNTW = $clog2(REF_INTERVAL) + 1;
  localparam int WW   = 8;

  localparam logic [2:0] S_IDLE = 3'd0, S_PRE = 3'd1, S_PRE_WAIT = 3'd2, S_ACT = 3'd3,
                         S_ACT_WAIT = 3'd4, S_ACCESS = 3'd5, S_REF = 3'd6, S_REF_WAIT = 3'd7;

  // Wait counters count down to 0, so a *_WAIT state lasts T-1 cycles.
  localparam logic [WW-1:0] RP_LD  = WW'(T_RP - 2);
  localparam logic [WW-1:0] RCD_LD = WW'(T_RCD - 2);
  localparam logic [WW-1:0] RFC_LD = WW'(T_RFC - 2);
  localparam logic [CNTW-1:0] REF_MAX = CNTW'(REF_INTERVAL - 1);

  logic [2:0]       state_q, state_d, pre_tgt_q, pre_tgt_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic [IW-1:0]    rr_q, rr_d, win_idx_q, win_idx_d, arb_idx;
  logic             arb_found, arb_rwb, hit;
  logic [2:0]       arb_bank, win_bank_q, win_bank_d, open_bank_q;
  logic [ROW_W-1:0] arb_row, win_row_q, win_row_d, open_row_q;
  logic [COL_W-1:0] arb_col, win_col_q, win_col_d;
  logic             win_rwb_q, win_rwb_d, open_valid_q;
  logic [CNTW-1:0]  ref_cnt_q;
  logic             ref_pend_q;

  logic [NUM_REQ-1:0] req_ready_q;
  logic               cmd_act_q, cmd_pre_q, cmd_rd_q, cmd_wr_q, cmd_ref_q, busy_q;
  logic [2:0]         cmd_bank_q;
  logic [ROW_W-1:0]   cmd_row_q;
  logic [COL_W-1:0]   cmd_col_q;

  // Round-robin search starting at rr_q.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!arb_found && req_valid[(int'(rr_q) + i) % NUM_REQ]) begin
        arb_found = 1'b1;
        arb_idx   = IW'((int'(rr_q) + i) % NUM_REQ);
      end
    end
    arb_rwb  = req_rwb[arb_idx];
    arb_bank = req_bank[int'(arb_idx)*3 +: 3];
    arb_row  = req_row[int'(arb_idx)*ROW_W +: ROW_W];
    arb_col  = req_col[int'(arb_idx)*COL_W +: COL_W];
    hit      = open_valid_q && (open_bank_q == arb_bank) && (open_row_q == arb_row);
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    pre_tgt_d = pre_tgt_q;
    rr_d      = rr_q;
    win_idx_d = win_idx_q;
    win_rwb_d = win_rwb_q;
    win_bank_d = win_bank_q;
    win_row_d = win_row_q;
    win_col_d = win_col_q;
    case (state_q)
      S_IDLE: begin
        if (ref_pend_q) begin
          // pre_tgt remembers why PRE was issued, so a refresh that becomes
          // pending later cannot hijack a PRE->ACT sequence already started.
          if (open_valid_q) begin
            state_d   = S_PRE;
            pre_tgt_d = S_REF;
          end else begin
            state_d = S_REF;
          end
        end else if (arb_found) begin
          win_idx_d  = arb_idx;
          win_rwb_d  = arb_rwb;
          win_bank_d = arb_bank;
          win_row_d  = arb_row;
          win_col_d  = arb_col;
          rr_d       = IW'((int'(arb_idx) + 1) % NUM_REQ);
          if (hit) begin
            state_d = S_ACCESS;
          end else if (open_valid_q) begin
            state_d   = S_PRE;
            pre_tgt_d = S_ACT;
          end else begin
            state_d = S_ACT;
          end
        end
      end
      S_PRE: begin
        if (T_RP == 1) state_d = pre_tgt_q;
        else begin
          state_d = S_PRE_WAIT;
          wait_d  = RP_LD;
        end
      end
      S_PRE_WAIT: begin
        if (wait_q == '0) state_d = pre_tgt_q;
        else wait_d = wait_q - 1'b1;
      end
      S_ACT: begin
        if (T_RCD == 1) state_d = S_ACCESS;
        else begin
          state_d = S_ACT_WAIT;
          wait_d  = RCD_LD;
        end
      end
      S_ACT_WAIT: begin
        if (wait_q == '0) state_d = S_ACCESS;
        else wait_d = wait_q - 1'b1;
      end
      S_ACCESS: begin
`ifdef CLOSE_PAGE_EN
        state_d   = S_PRE;
        pre_tgt_d = S_IDLE;
`else
        state_d = S_IDLE;
`endif
      end
      S_REF: begin
        if (T_RFC == 1) state_d = S_IDLE;
        else begin
          state_d = S_REF_WAIT;
          wait_d  = RFC_LD;
        end
      end
      S_REF_WAIT: begin
        if (wait_q == '0) state_d = S_IDLE;
        else wait_d = wait_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_t) begin
    if (reset) begin
      state_q <= S_IDLE;    pre_tgt_q <= S_ACT;  wait_q <= '0;
      rr_q <= '0;           win_idx_q <= '0;     win_rwb_q <= 1'b0;
      win_bank_q <= '0;     win_row_q <= '0;     win_col_q <= '0;
      open_valid_q <= 1'b0; open_bank_q <= '0;   open_row_q <= '0;
      ref_cnt_q <= '0;      ref_pend_q <= 1'b0;
      req_ready_q <= '0;    busy_q <= 1'b0;
      cmd_act_q <= 1'b0;    cmd_pre_q <= 1'b0;   cmd_rd_q <= 1'b0;
      cmd_wr_q <= 1'b0;     cmd_ref_q <= 1'b0;
      cmd_bank_q <= '0;     cmd_row_q <= '0;     cmd_col_q <= '0;
    end else begin
      state_q    <= state_d;   pre_tgt_q <= pre_tgt_d; wait_q <= wait_d;
      rr_q       <= rr_d;      win_idx_q <= win_idx_d; win_rwb_q <= win_rwb_d;
      win_bank_q <= win_bank_d; win_row_q <= win_row_d; win_col_q <= win_col_d;

      if (state_d == S_PRE) begin
        open_valid_q <= 1'b0;
      end else if (state_d == S_ACT) begin
        open_valid_q <= 1'b1;
        open_bank_q  <= win_bank_d;
        open_row_q   <= win_row_d;
      end

      // Refresh timer: cleared by REF, frozen during REF_WAIT, saturates.
      if (state_q == S_REF) begin
        ref_cnt_q  <= '0;
        ref_pend_q <= 1'b0;
      end else if (state_q != S_REF_WAIT) begin
        if (ref_cnt_q == REF_MAX) ref_pend_q <= 1'b1;
        else ref_cnt_q <= ref_cnt_q + 1'b1;
      end

      busy_q      <= (state_d != S_IDLE);
      cmd_act_q   <= (state_d == S_ACT);
      cmd_pre_q   <= (state_d == S_PRE);
      cmd_rd_q    <= (state_d == S_ACCESS) && !win_rwb_d;
      cmd_wr_q    <= (state_d == S_ACCESS) && win_rwb_d;
      cmd_ref_q   <= (state_d == S_REF);
      req_ready_q <= (state_d == S_ACCESS) ? (NUM_REQ'(1) << win_idx_d) : '0;
      cmd_bank_q  <= '0;
      cmd_row_q   <= '0;
      cmd_col_q   <= '0;
      case (state_d)
        S_PRE: begin
          cmd_bank_q <= open_bank_q;
          cmd_row_q  <= open_row_q;
        end
        S_ACT: begin
          cmd_bank_q <= win_bank_d;
          cmd_row_q  <= win_row_d;
        end
        S_ACCESS: begin
          cmd_bank_q <= win_bank_d;
          cmd_col_q  <= win_col_d;
        end
        default: ;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign cmd_act   = cmd_act_q;
  assign cmd_pre   = cmd_pre_q;
  assign cmd_rd    = cmd_rd_q;
  assign cmd_wr    = cmd_wr_q;
  assign cmd_ref   = cmd_ref_q;
  assign cmd_bank  = cmd_bank_q;
  assign cmd_row   = cmd_row_q;
  assign cmd_col   = cmd_col_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_ddr_cmd_scheduler.sv
// Directed bench for ddr_cmd_scheduler with default parameters
// (NUM_REQ=2, T_RCD=2, T_RP=2, T_RFC=5, REF_INTERVAL=64).
module tb_ddr_cmd_scheduler;
  localparam int NR = 2, RW = 3, CW = 3;
  localparam logic [4:0] C_NONE = 5'b00000, C_ACT = 5'b10000, C_PRE = 5'b01000,
                         C_RD = 5'b00100, C_WR = 5'b00010, C_REF = 5'b00001;

  logic clk_t = 1'b0;
  logic reset = 1'b1;
  logic [NR-1:0]    req_valid = '0, req_rwb = '0, req_ready;
  logic [3*NR-1:0]  req_bank = '0;
  logic [RW*NR-1:0] req_row = '0;
  logic [CW*NR-1:0] req_col = '0;
  logic cmd_act, cmd_pre, cmd_rd, cmd_wr, cmd_ref, busy;
  logic [2:0]    cmd_bank;
  logic [RW-1:0] cmd_row;
  logic [CW-1:0] cmd_col;

  int checks = 0, failures = 0, cyc = 0;

  ddr_cmd_scheduler dut (
    .clk_t(clk_t), .reset(reset), .req_valid(req_valid), .req_rwb(req_rwb),
    .req_bank(req_bank), .req_row(req_row), .req_col(req_col), .req_ready(req_ready),
    .cmd_act(cmd_act), .cmd_pre(cmd_pre), .cmd_rd(cmd_rd), .cmd_wr(cmd_wr),
    .cmd_ref(cmd_ref), .cmd_bank(cmd_bank), .cmd_row(cmd_row), .cmd_col(cmd_col),
    .busy(busy)
  );

  always #5 clk_t = ~clk_t;

  function automatic logic [4:0] cmdv();
    return {cmd_act, cmd_pre, cmd_rd, cmd_wr, cmd_ref};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_t);
    #1;
    cyc++;
  endtask

  task automatic set_req(input int i, input logic v, input logic w,
                         input logic [2:0] b, input logic [2:0] r, input logic [2:0] c);
    req_valid[i]        = v;
    req_rwb[i]          = w;
    req_bank[i*3 +: 3]  = b;
    req_row[i*RW +: RW] = r;
    req_col[i*CW +: CW] = c;
  endtask

  initial begin : main
    logic [4:0] c, h1, h2;
    int tpre, tref, tref2;
    bit seen;
    h1 = C_NONE; h2 = C_NONE; tpre = 0; tref = 0; tref2 = 0; seen = 0;

    // Reset state
    tick(); tick(); tick();
    chk("rst_cmd", cmdv(), C_NONE);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 0);
    reset = 1'b0;

`ifndef CLOSE_PAGE_EN
    // 1: reset during ACT_WAIT drops the sequence and the open row
    set_req(0, 1, 0, 3'd1, 3'd2, 3'd0);
    tick(); chk("t1_act", cmdv(), C_ACT);
    tick(); chk("t1_actwait_busy", busy, 1);
    reset = 1'b1;
    for (int n = 0; n < 3; n++) begin
      tick();
      chk("t1_rst_cmd", cmdv(), C_NONE);
      chk("t1_rst_busy", busy, 0);
      chk("t1_rst_ready", req_ready, 0);
    end
    set_req(0, 0, 0, 3'd0, 3'd0, 3'd0);
    reset = 1'b0;
    tick(); chk("t1_idle", cmdv(), C_NONE);

    // 2: closed miss write -> ACT, then WR T_RCD later (no PRE after reset)
    set_req(0, 1, 1, 3'd3, 3'd5, 3'd2);
    tick(); chk("t2_act", cmdv(), C_ACT);
    chk("t2_act_bank", cmd_bank, 3); chk("t2_act_row", cmd_row, 5);
    tick(); chk("t2_gap", cmdv(), C_NONE);
    tick(); chk("t2_wr", cmdv(), C_WR);
    chk("t2_col", cmd_col, 2); chk("t2_ready", req_ready, 2'b01);
    set_req(0, 0, 0, 3'd0, 3'd0, 3'd0);
    tick(); chk("t2_done", cmdv(), C_NONE);

    // 3: hit -> RD next cycle; then miss on same bank -> PRE, ACT, RD
    set_req(0, 1, 0, 3'd3, 3'd5, 3'd7);
    tick(); chk("t3_hit_rd", cmdv(), C_RD);
    chk("t3_hit_col", cmd_col, 7); chk("t3_hit_ready", req_ready, 2'b01);
    set_req(0, 0, 0, 3'd0, 3'd0, 3'd0);
    tick();
    set_req(0, 1, 0, 3'd3, 3'd6, 3'd1);
    tick(); chk("t3_pre", cmdv(), C_PRE); chk("t3_pre_row", cmd_row, 5);
    chk("t3_pre_bank", cmd_bank, 3);
    tick(); chk("t3_trp_gap", cmdv(), C_NONE);
    tick(); chk("t3_act", cmdv(), C_ACT); chk("t3_act_row", cmd_row, 6);
    tick(); chk("t3_trcd_gap", cmdv(), C_NONE);
    tick(); chk("t3_rd", cmdv(), C_RD); chk("t3_rd_col", cmd_col, 1);
    chk("t3_ready", req_ready, 2'b01);
    set_req(0, 0, 0, 3'd0, 3'd0, 3'd0);
    tick();

    // req1 hit: moves round-robin pointer back to 0
    set_req(1, 1, 0, 3'd3, 3'd6, 3'd3);
    tick(); chk("rr_prep_ready", req_ready, 2'b10);
    set_req(1, 0, 0, 3'd0, 3'd0, 3'd0);
    tick();

    // 4: round-robin alternation on hits
    set_req(0, 1, 0, 3'd3, 3'd6, 3'd4);
    set_req(1, 1, 0, 3'd3, 3'd6, 3'd5);
    for (int k = 0; k < 4; k++) begin
      for (int n = 0; n < 4; n++) begin
        tick();
        if (req_ready != '0) break;
      end
      chk("t4_rr_ready", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
      chk("t4_rr_col", cmd_col, (k % 2 == 0) ? 3'd4 : 3'd5);
    end

    // 5: refresh with row open while both requesters stay busy
    for (int n = 0; n < 200 && !seen; n++) begin
      tick();
      c = cmdv();
      if (c == C_REF) begin
        seen = 1; tref = cyc;
      end else if (c != C_NONE) begin
        h2 = h1; h1 = c;
        if (c == C_PRE) tpre = cyc;
      end
    end
    chk("t5_ref_seen", seen, 1);
    chk("t5_pre_before_ref", h1, C_PRE);
    chk("t5_access_before_pre", h2, C_RD);
    chk("t5_trp_to_ref", tref - tpre, 2);
    for (int n = 0; n < 5; n++) begin
      tick(); chk("t5_rfc_quiet", cmdv(), C_NONE);
    end
    tick(); chk("t5_resume_act", cmdv(), C_ACT);
    for (int n = 0; n < 6 && req_ready == '0; n++) tick();
    chk("t5_resume_ready", |req_ready, 1);
    set_req(0, 0, 0, 3'd0, 3'd0, 3'd0);
    set_req(1, 0, 0, 3'd0, 3'd0, 3'd0);
    seen = 0;
    for (int n = 0; n < 150 && !seen; n++) begin
      tick();
      if (cmdv() == C_REF) begin
        seen = 1; tref2 = cyc;
      end
    end
    chk("t5_ref2_seen", seen, 1);
    // counter restarts at 0 after REF_WAIT: 64 counts + open-row PRE/tRP
    chk("t5_ref_interval", tref2 - tref, 72);
`else
    // 6: close-page -> every read is ACT, RD, PRE, even for the same row
    for (int k = 0; k < 2; k++) begin
      set_req(0, 1, 0, 3'd2, 3'd1, 3'd4);
      tick(); chk("t6_act", cmdv(), C_ACT); chk("t6_act_row", cmd_row, 1);
      tick(); chk("t6_gap", cmdv(), C_NONE);
      tick(); chk("t6_rd", cmdv(), C_RD); chk("t6_ready", req_ready, 2'b01);
      chk("t6_col", cmd_col, 4);
      set_req(0, 0, 0, 3'd0, 3'd0, 3'd0);
      tick(); chk("t6_pre", cmdv(), C_PRE); chk("t6_pre_bank", cmd_bank, 2);
      tick(); chk("t6_trp_gap", cmdv(), C_NONE);
      tick(); chk("t6_idle_busy", busy, 0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
